// File: rtl/sram_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// sram_arb_pkg: shared types and helpers for the SRAM port arbiter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sram_arb_pkg;

  localparam int MEM_RD_LATENCY = 1;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  // Index width for n items, never below 1 so single-bit indices stay legal.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// sram_port_arbiter_if: requester-side bus of the SRAM port arbiter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface sram_port_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            lock;
  logic [NUM_REQ-1:0]            we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]         rdata;

  modport master (output req, lock, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, lock, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

`default_nettype wire

// File: rtl/sram_port_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// sram_arb_rr_pick: combinational round-robin picker, search starts at ptr_i.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sram_arb_rr_pick
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = clog2(NUM_REQ)
) (
  input  wire  [NUM_REQ-1:0] req_i,
  input  wire  [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o
);

  int cand;

  // Scan from farthest to nearest offset so the nearest active request wins.
  always_comb begin
    cand  = 0;
    idx_o = ptr_i;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req_i[cand]) idx_o = IW'(cand);
    end
    gnt_o        = '0;
    gnt_o[idx_o] = |req_i;
  end

endmodule

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
// ----------------------------------------------------------------------------
// sram_port_arbiter: round-robin single-port SRAM sharing with grant locking.
// Optional macro SRAM_ARB_BURST_LIMIT_EN caps locked bursts at MAX_BURST. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REQ    = 2,
  parameter int MAX_BURST  = 16
) (
  input  wire                    clk,
  input  wire                    resetn,
  sram_port_arbiter_if.slave     bus,
  output logic                   csb0_o,
  output logic                   web0_o,
  output logic [ADDR_WIDTH-1:0]  addr0_o,
  output logic [DATA_WIDTH-1:0]  din0_o,
  input  wire  [DATA_WIDTH-1:0]  dout0_i
);

  localparam int IW        = clog2(NUM_REQ);
  localparam int TAG_DEPTH = MEM_RD_LATENCY + 1;

  arb_state_e             state_q, state_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]     pick_gnt, gnt;
  logic [IW-1:0]          pick_idx, gnt_idx;
  logic                   accept;
  logic                   burst_done;

  logic                   csb_q, web_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  din_q;

  logic [TAG_DEPTH-1:0]   tag_vld_q;
  logic [IW-1:0]          tag_idx_q [TAG_DEPTH];

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  sram_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req_i (bus.req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ARB;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Every accepted access moves the pointer past the winner, so leaving
  // ownership already finds the pointer one beyond the owner.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = accept ? next_idx(gnt_idx) : rr_ptr_q;
    case (state_q)
      ARB: begin
        if (accept && bus.lock[gnt_idx]) begin
          state_d = OWNED;
          owner_d = gnt_idx;
        end
      end
      OWNED: begin
        if (!bus.lock[owner_q]) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    if (burst_done) state_d = ARB;
  end

  always_comb begin
    gnt     = '0;
    gnt_idx = pick_idx;
    if (state_q == OWNED) begin
      gnt[owner_q] = 1'b1;
      gnt_idx      = owner_q;
    end else begin
      gnt = pick_gnt;
    end
    if (!resetn) gnt = '0;
  end

  assign bus.gnt = gnt;
  assign accept  = |(gnt & bus.req);

`ifdef SRAM_ARB_BURST_LIMIT_EN
  localparam int CW = clog2(MAX_BURST + 1);

  logic [CW-1:0] burst_q, burst_d;

  assign burst_done = accept && (burst_q == CW'(MAX_BURST - 1));

  always_comb begin
    burst_d = burst_q;
    if (state_d == ARB) burst_d = '0;
    else if (accept)    burst_d = burst_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) burst_q <= '0;
    else         burst_q <= burst_d;
  end
`else
  logic unused_max_burst;
  assign unused_max_burst = (MAX_BURST > 0);
  assign burst_done       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      csb_q  <= 1'b1;
      web_q  <= 1'b1;
      addr_q <= '0;
      din_q  <= '0;
    end else if (accept) begin
      csb_q  <= 1'b0;
      web_q  <= ~bus.we[gnt_idx];
      addr_q <= bus.addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      din_q  <= bus.wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      csb_q  <= 1'b1;
      web_q  <= 1'b1;
    end
  end

  assign csb0_o  = csb_q;
  assign web0_o  = web_q;
  assign addr0_o = addr_q;
  assign din0_o  = din_q;

  // Stage 0 travels with the memory command; the last stage lines up with dout0.
  always_ff @(posedge clk) begin
    if (!resetn) tag_vld_q <= '0;
    else         tag_vld_q <= {tag_vld_q[TAG_DEPTH-2:0], accept & ~bus.we[gnt_idx]};
  end

  always_ff @(posedge clk) begin
    tag_idx_q[0] <= gnt_idx;
    for (int s = 1; s < TAG_DEPTH; s++) tag_idx_q[s] <= tag_idx_q[s-1];
  end

  always_comb begin
    bus.rvalid = '0;
    if (resetn && tag_vld_q[TAG_DEPTH-1]) bus.rvalid[tag_idx_q[TAG_DEPTH-1]] = 1'b1;
  end

  assign bus.rdata = dout0_i;

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sram_port_arbiter: directed vectors plus randomized traffic checked
// against a rule-level arbiter/memory reference model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sram_port_arbiter;

  localparam int NREQ = 2;
`ifdef SRAM_ARB_BURST_LIMIT_EN
  localparam int MB = 4;
`else
  localparam int MB = 16;
`endif

  typedef struct {
    logic [1:0] req, lock, we;
    logic [7:0] a0, a1, d0, d1;
    logic [1:0] e_gnt;
    logic       e_csb, e_web;
    logic [7:0] e_maddr;
    logic [1:0] e_rv;
    logic [7:0] e_rd;
    bit         chk;
  } vec_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       csb0, web0;
  logic [7:0] addr0, din0;
  logic [7:0] dout0 = 8'h00;
  logic [7:0] mem [256];

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int         m_owner = -1, m_rr = 0, m_cnt = 0, m_cmd_req = 0, m_rv_req = -1;
  logic       m_csb = 1'b1, m_web = 1'b1;
  logic [7:0] m_addr = 8'h00, m_din = 8'h00, m_rv_data = 8'h00;
  logic [7:0] ref_mem [256];

  vec_t tbl [13];

  sram_port_arbiter_if #(.NUM_REQ(NREQ), .ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  sram_port_arbiter #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .NUM_REQ    (NREQ),
    .MAX_BURST  (MB)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus),
    .csb0_o  (csb0),
    .web0_o  (web0),
    .addr0_o (addr0),
    .din0_o  (din0),
    .dout0_i (dout0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (csb0 == 1'b0) begin
      if (web0 == 1'b0) mem[addr0] <= din0;
      else              dout0 <= mem[addr0];
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] rq, lk, w, input logic [7:0] a0, a1, d0, d1,
                              input logic [1:0] eg, input logic ecsb, eweb,
                              input logic [7:0] ema, input logic [1:0] erv, input logic [7:0] erd);
    vec_t v;
    v.req = rq; v.lock = lk; v.we = w;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.e_gnt = eg; v.e_csb = ecsb; v.e_web = eweb;
    v.e_maddr = ema; v.e_rv = erv; v.e_rd = erd;
    v.chk = 1'b1;
    return v;
  endfunction

  // Owner keeps the grant; otherwise the first active requester from m_rr wins.
  function automatic int model_pick(input logic [1:0] rq);
    int g;
    g = -1;
    if (m_owner >= 0) return m_owner;
    for (int k = 0; k < NREQ; k++) begin
      if (g < 0 && rq[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
    end
    return g;
  endfunction

  task automatic model_advance(input vec_t v, input int g);
    bit acc;
    acc = (g >= 0) && v.req[g];
    m_rv_req = -1;
    if (!m_csb && m_web) begin
      m_rv_req  = m_cmd_req;
      m_rv_data = ref_mem[m_addr];
    end
    if (!m_csb && !m_web) ref_mem[m_addr] = m_din;
    if (acc) begin
      m_csb     = 1'b0;
      m_web     = ~v.we[g];
      m_addr    = (g == 1) ? v.a1 : v.a0;
      m_din     = (g == 1) ? v.d1 : v.d0;
      m_cmd_req = g;
      m_rr      = (g + 1) % NREQ;
    end else begin
      m_csb = 1'b1;
      m_web = 1'b1;
    end
    if (m_owner < 0) begin
      if (acc && v.lock[g]) begin
        m_owner = g;
        m_cnt   = 1;
      end
    end else begin
      if (acc) m_cnt++;
      if (!v.lock[m_owner]) begin
        m_owner = -1;
        m_cnt   = 0;
      end
    end
`ifdef SRAM_ARB_BURST_LIMIT_EN
    if (m_owner >= 0 && m_cnt >= MB) begin
      m_owner = -1;
      m_cnt   = 0;
    end
`endif
  endtask

  task automatic apply(input vec_t v);
    int g;
    logic [1:0] eg, erv;
    @(negedge clk);
    bus.req   = v.req;
    bus.lock  = v.lock;
    bus.we    = v.we;
    bus.addr  = {v.a1, v.a0};
    bus.wdata = {v.d1, v.d0};
    #1;
    g   = model_pick(v.req);
    eg  = (g < 0) ? 2'b00 : 2'(1 << g);
    erv = (m_rv_req < 0) ? 2'b00 : 2'(1 << m_rv_req);
    check("gnt", 32'(bus.gnt), 32'(eg));
    check("csb0", 32'(csb0), 32'(m_csb));
    check("web0", 32'(web0), 32'(m_web));
    check("addr0", 32'(addr0), 32'(m_addr));
    check("din0", 32'(din0), 32'(m_din));
    check("rvalid", 32'(bus.rvalid), 32'(erv));
    if (m_rv_req >= 0) check("rdata", 32'(bus.rdata), 32'(m_rv_data));
    if (v.chk) begin
      check("vec_gnt", 32'(bus.gnt), 32'(v.e_gnt));
      check("vec_csb0", 32'(csb0), 32'(v.e_csb));
      check("vec_web0", 32'(web0), 32'(v.e_web));
      check("vec_addr0", 32'(addr0), 32'(v.e_maddr));
      check("vec_rvalid", 32'(bus.rvalid), 32'(v.e_rv));
      if (v.e_rv != 2'b00) check("vec_rdata", 32'(bus.rdata), 32'(v.e_rd));
    end
    model_advance(v, g);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn   = 1'b0;
    bus.req  = '0;
    bus.lock = '0;
    bus.we   = '0;
    #1;
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    if (!m_csb && !m_web) ref_mem[m_addr] = m_din;
    @(posedge clk);
    #1;
    resetn   = 1'b1;
    m_owner  = -1; m_rr = 0; m_cnt = 0; m_rv_req = -1;
    m_csb    = 1'b1; m_web = 1'b1; m_addr = 8'h00; m_din = 8'h00;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      mem[a]     = 8'(a) ^ 8'hA2;
      ref_mem[a] = 8'(a) ^ 8'hA2;
    end
    bus.req = '0; bus.lock = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;

    //           req    lock   we     a0     a1     d0  d1     gnt    csb   web   maddr  rv     rdata
    tbl[0]  = mk(2'b01, 2'b00, 2'b00, 8'h05, 8'h00, 0, 8'h00, 2'b01, 1'b1, 1'b1, 8'h00, 2'b00, 8'h00);
    tbl[1]  = mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 8'h00, 2'b00, 1'b0, 1'b1, 8'h05, 2'b00, 8'h00);
    tbl[2]  = mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 8'h00, 2'b00, 1'b1, 1'b1, 8'h05, 2'b01, 8'hA7);
    tbl[3]  = mk(2'b11, 2'b00, 2'b00, 8'h20, 8'h31, 0, 8'h00, 2'b10, 1'b1, 1'b1, 8'h05, 2'b00, 8'h00);
    tbl[4]  = mk(2'b11, 2'b00, 2'b00, 8'h20, 8'h31, 0, 8'h00, 2'b01, 1'b0, 1'b1, 8'h31, 2'b00, 8'h00);
    tbl[5]  = mk(2'b11, 2'b00, 2'b00, 8'h20, 8'h31, 0, 8'h00, 2'b10, 1'b0, 1'b1, 8'h20, 2'b10, 8'h93);
    tbl[6]  = mk(2'b11, 2'b00, 2'b00, 8'h20, 8'h31, 0, 8'h00, 2'b01, 1'b0, 1'b1, 8'h31, 2'b01, 8'h82);
    tbl[7]  = mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 8'h00, 2'b00, 1'b0, 1'b1, 8'h20, 2'b10, 8'h93);
    tbl[8]  = mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 8'h00, 2'b00, 1'b1, 1'b1, 8'h20, 2'b01, 8'h82);
    tbl[9]  = mk(2'b10, 2'b00, 2'b10, 8'h00, 8'h10, 0, 8'h3C, 2'b10, 1'b1, 1'b1, 8'h20, 2'b00, 8'h00);
    tbl[10] = mk(2'b10, 2'b00, 2'b00, 8'h00, 8'h10, 0, 8'h00, 2'b10, 1'b0, 1'b0, 8'h10, 2'b00, 8'h00);
    tbl[11] = mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 8'h00, 2'b00, 1'b0, 1'b1, 8'h10, 2'b00, 8'h00);
    tbl[12] = mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 8'h00, 2'b00, 1'b1, 1'b1, 8'h10, 2'b10, 8'h3C);

    do_reset();
    for (int i = 0; i < 13; i++) apply(tbl[i]);

`ifndef SRAM_ARB_BURST_LIMIT_EN
    // Requester 0 holds the lock for five accesses, releasing on the fifth.
    apply(mk(2'b11, 2'b01, 2'b00, 8'h40, 8'h50, 0, 0, 2'b01, 1'b1, 1'b1, 8'h10, 2'b00, 8'h00));
    apply(mk(2'b11, 2'b01, 2'b00, 8'h40, 8'h50, 0, 0, 2'b01, 1'b0, 1'b1, 8'h40, 2'b00, 8'h00));
    apply(mk(2'b11, 2'b01, 2'b00, 8'h40, 8'h50, 0, 0, 2'b01, 1'b0, 1'b1, 8'h40, 2'b01, 8'hE2));
    apply(mk(2'b11, 2'b01, 2'b00, 8'h40, 8'h50, 0, 0, 2'b01, 1'b0, 1'b1, 8'h40, 2'b01, 8'hE2));
    apply(mk(2'b11, 2'b00, 2'b00, 8'h40, 8'h50, 0, 0, 2'b01, 1'b0, 1'b1, 8'h40, 2'b01, 8'hE2));
    apply(mk(2'b11, 2'b00, 2'b00, 8'h40, 8'h50, 0, 0, 2'b10, 1'b0, 1'b1, 8'h40, 2'b01, 8'hE2));
    apply(mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 1'b0, 1'b1, 8'h50, 2'b01, 8'hE2));
    apply(mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 1'b1, 1'b1, 8'h50, 2'b10, 8'hF2));
`else
    // Lock never dropped: the burst cap hands slot five to requester 1.
    apply(mk(2'b11, 2'b01, 2'b00, 8'h40, 8'h50, 0, 0, 2'b01, 1'b1, 1'b1, 8'h10, 2'b00, 8'h00));
    apply(mk(2'b11, 2'b01, 2'b00, 8'h40, 8'h50, 0, 0, 2'b01, 1'b0, 1'b1, 8'h40, 2'b00, 8'h00));
    apply(mk(2'b11, 2'b01, 2'b00, 8'h40, 8'h50, 0, 0, 2'b01, 1'b0, 1'b1, 8'h40, 2'b01, 8'hE2));
    apply(mk(2'b11, 2'b01, 2'b00, 8'h40, 8'h50, 0, 0, 2'b01, 1'b0, 1'b1, 8'h40, 2'b01, 8'hE2));
    apply(mk(2'b11, 2'b01, 2'b00, 8'h40, 8'h50, 0, 0, 2'b10, 1'b0, 1'b1, 8'h40, 2'b01, 8'hE2));
    apply(mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 1'b0, 1'b1, 8'h50, 2'b01, 8'hE2));
    apply(mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 1'b1, 1'b1, 8'h50, 2'b10, 8'hF2));
`endif

    // Owner drops req but keeps lock: grant held, memory idle.
    apply(mk(2'b01, 2'b01, 2'b00, 8'h60, 8'h50, 0, 0, 2'b01, 1'b1, 1'b1, 8'h50, 2'b00, 8'h00));
    apply(mk(2'b10, 2'b01, 2'b00, 8'h60, 8'h50, 0, 0, 2'b01, 1'b0, 1'b1, 8'h60, 2'b00, 8'h00));
    apply(mk(2'b10, 2'b01, 2'b00, 8'h60, 8'h50, 0, 0, 2'b01, 1'b1, 1'b1, 8'h60, 2'b01, 8'hC2));
    apply(mk(2'b10, 2'b00, 2'b00, 8'h60, 8'h50, 0, 0, 2'b01, 1'b1, 1'b1, 8'h60, 2'b00, 8'h00));
    apply(mk(2'b10, 2'b00, 2'b00, 8'h60, 8'h50, 0, 0, 2'b10, 1'b1, 1'b1, 8'h60, 2'b00, 8'h00));
    apply(mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 1'b0, 1'b1, 8'h50, 2'b00, 8'h00));
    apply(mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 1'b1, 1'b1, 8'h50, 2'b10, 8'hF2));

    // Reset pulse with two reads in flight.
    apply(mk(2'b11, 2'b00, 2'b00, 8'h05, 8'h31, 0, 0, 2'b01, 1'b1, 1'b1, 8'h50, 2'b00, 8'h00));
    apply(mk(2'b11, 2'b00, 2'b00, 8'h05, 8'h31, 0, 0, 2'b10, 1'b0, 1'b1, 8'h05, 2'b00, 8'h00));
    do_reset();
    apply(mk(2'b10, 2'b00, 2'b00, 8'h00, 8'h31, 0, 0, 2'b10, 1'b1, 1'b1, 8'h00, 2'b00, 8'h00));
    apply(mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 1'b0, 1'b1, 8'h31, 2'b00, 8'h00));
    apply(mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 1'b1, 1'b1, 8'h31, 2'b10, 8'h93));

    for (int c = 0; c < 3000; c++) begin
      vec_t v;
      if (c % 700 == 699) do_reset();
      v = mk(2'($urandom_range(0, 3)),
             {1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0)},
             2'($urandom_range(0, 3)),
             8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
             8'($urandom), 8'($urandom),
             2'b00, 1'b1, 1'b1, 8'h00, 2'b00, 8'h00);
      v.chk = 1'b0;
      apply(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
